// File: rtl/gps_acq_scheduler.sv
// Acquisition scheduler: walks PRN x Doppler-bin grid, launches the correlator per bin and
// peak-tracks results. Optional per-bin watchdog enabled by defining ACQ_SCHED_TIMEOUT_EN.
module gps_acq_scheduler #(
  parameter logic signed [15:0] DOPPLER_INIT = 16'sd13,
  parameter logic signed [15:0] DOPPLER_STEP = 16'sd13,
  parameter int unsigned        DOPPLER_NUM  = 2,
  parameter logic [11:0]        THRESHOLD    = 12'd300
`ifdef ACQ_SCHED_TIMEOUT_EN
  , parameter int unsigned      TIMEOUT_CYCLES = 2**24
`endif
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        abort,
  input  logic [5:0]  sat_first,
  input  logic [5:0]  sat_last,
  output logic        eng_start,
  output logic [5:0]  eng_sat,
  output logic [15:0] eng_doppler_omega,
  input  logic        eng_corr_complete,
  input  logic [9:0]  eng_code_phase,
  input  logic [4:0]  eng_code_nco_frac,
  input  logic [11:0] eng_integrator,
  input  logic        eng_search_complete,
  output logic        busy,
  output logic        res_valid,
  output logic [5:0]  res_sat,
  output logic [9:0]  res_code_phase,
  output logic [4:0]  res_frac,
  output logic [15:0] res_doppler,
  output logic [11:0] res_metric,
  output logic        res_detect,
  output logic        done,
  output logic        err_timeout
);

  typedef enum logic [2:0] {
    S_IDLE, S_SAT_INIT, S_LAUNCH, S_WAIT, S_BIN_NEXT, S_REPORT, S_DONE
  } state_t;

  localparam logic [7:0] BIN_LAST = 8'(DOPPLER_NUM - 1);

  state_t      state_q, state_d;
  logic [5:0]  sat_q, sat_d;
  logic [5:0]  sat_last_q, sat_last_d;
  logic [7:0]  bin_q, bin_d;
  logic [15:0] omega_q, omega_d;
  logic        corr_prev_q, corr_prev_d;
  logic [11:0] best_metric_q, best_metric_d;
  logic [9:0]  best_phase_q, best_phase_d;
  logic [4:0]  best_frac_q, best_frac_d;
  logic [15:0] best_doppler_q, best_doppler_d;
  logic        busy_q, busy_d;
  logic        eng_start_q, eng_start_d;
  logic        res_valid_q, res_valid_d;
  logic [5:0]  res_sat_q, res_sat_d;
  logic [9:0]  res_phase_q, res_phase_d;
  logic [4:0]  res_frac_q, res_frac_d;
  logic [15:0] res_doppler_q, res_doppler_d;
  logic [11:0] res_metric_q, res_metric_d;
  logic        res_detect_q, res_detect_d;
  logic        done_q, done_d;
`ifdef ACQ_SCHED_TIMEOUT_EN
  logic [31:0] cnt_q, cnt_d;
  logic        err_q, err_d;
`endif

  logic        corr_rise;
  logic [11:0] metric;

  assign corr_rise = eng_corr_complete && !corr_prev_q;
  // Distance from the uncorrelated midpoint; 0 maps to 2048, which still fits 12 bits.
  assign metric = eng_integrator[11] ? {1'b0, eng_integrator[10:0]}
                                     : 12'd2048 - eng_integrator;

  always_comb begin
    // NOTE: every _d gets a default first so no path through the case infers a latch.
    state_d        = state_q;
    sat_d          = sat_q;
    sat_last_d     = sat_last_q;
    bin_d          = bin_q;
    omega_d        = omega_q;
    corr_prev_d    = eng_corr_complete;
    best_metric_d  = best_metric_q;
    best_phase_d   = best_phase_q;
    best_frac_d    = best_frac_q;
    best_doppler_d = best_doppler_q;
    eng_start_d    = 1'b0;
    res_valid_d    = 1'b0;
    res_sat_d      = res_sat_q;
    res_phase_d    = res_phase_q;
    res_frac_d     = res_frac_q;
    res_doppler_d  = res_doppler_q;
    res_metric_d   = res_metric_q;
    res_detect_d   = res_detect_q;
    done_d         = 1'b0;
`ifdef ACQ_SCHED_TIMEOUT_EN
    cnt_d          = cnt_q;
    err_d          = err_q;
`endif

    unique case (state_q)
      S_IDLE: begin
        if (start && !abort) begin
          state_d    = S_SAT_INIT;
          sat_d      = sat_first;
          sat_last_d = (sat_first > sat_last) ? sat_first : sat_last;
`ifdef ACQ_SCHED_TIMEOUT_EN
          err_d      = 1'b0;
`endif
        end
      end
      S_SAT_INIT: begin
        omega_d        = DOPPLER_INIT;
        bin_d          = 8'd0;
        best_metric_d  = 12'd0;
        best_phase_d   = 10'd0;
        best_frac_d    = 5'd0;
        best_doppler_d = 16'd0;
        eng_start_d    = 1'b1;
        state_d        = S_LAUNCH;
      end
      S_LAUNCH: begin
        state_d = S_WAIT;
`ifdef ACQ_SCHED_TIMEOUT_EN
        cnt_d   = 32'd0;
`endif
      end
      S_WAIT: begin
        // Sample before leaving so a result coincident with bin completion is kept.
        if (corr_rise && (metric > best_metric_q)) begin
          best_metric_d  = metric;
          best_phase_d   = eng_code_phase;
          best_frac_d    = eng_code_nco_frac;
          best_doppler_d = omega_q;
        end
        if (eng_search_complete) begin
          state_d = S_BIN_NEXT;
`ifdef ACQ_SCHED_TIMEOUT_EN
        end else if (cnt_q == TIMEOUT_CYCLES - 1) begin
          err_d   = 1'b1;
          state_d = S_BIN_NEXT;
        end else begin
          cnt_d   = cnt_q + 32'd1;
`endif
        end
      end
      S_BIN_NEXT: begin
        if (bin_q < BIN_LAST) begin
          bin_d       = bin_q + 8'd1;
          omega_d     = omega_q + DOPPLER_STEP;
          eng_start_d = 1'b1;
          state_d     = S_LAUNCH;
        end else begin
          res_valid_d   = 1'b1;
          res_sat_d     = sat_q;
          res_phase_d   = best_phase_q;
          res_frac_d    = best_frac_q;
          res_doppler_d = best_doppler_q;
          res_metric_d  = best_metric_q;
          res_detect_d  = best_metric_q >= THRESHOLD;
          state_d       = S_REPORT;
        end
      end
      S_REPORT: begin
        if (sat_q < sat_last_q) begin
          sat_d   = sat_q + 6'd1;
          state_d = S_SAT_INIT;
        end else begin
          done_d  = 1'b1;
          state_d = S_DONE;
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (abort && (state_q != S_IDLE)) begin
      state_d     = S_IDLE;
      eng_start_d = 1'b0;
      res_valid_d = 1'b0;
      done_d      = 1'b0;
    end

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q        <= S_IDLE;
      sat_q          <= 6'd0;
      sat_last_q     <= 6'd0;
      bin_q          <= 8'd0;
      omega_q        <= 16'd0;
      corr_prev_q    <= 1'b0;
      best_metric_q  <= 12'd0;
      best_phase_q   <= 10'd0;
      best_frac_q    <= 5'd0;
      best_doppler_q <= 16'd0;
      busy_q         <= 1'b0;
      eng_start_q    <= 1'b0;
      res_valid_q    <= 1'b0;
      res_sat_q      <= 6'd0;
      res_phase_q    <= 10'd0;
      res_frac_q     <= 5'd0;
      res_doppler_q  <= 16'd0;
      res_metric_q   <= 12'd0;
      res_detect_q   <= 1'b0;
      done_q         <= 1'b0;
`ifdef ACQ_SCHED_TIMEOUT_EN
      cnt_q          <= 32'd0;
      err_q          <= 1'b0;
`endif
    end else begin
      // NOTE: non-blocking assignments so every flop samples the pre-edge values.
      state_q        <= state_d;
      sat_q          <= sat_d;
      sat_last_q     <= sat_last_d;
      bin_q          <= bin_d;
      omega_q        <= omega_d;
      corr_prev_q    <= corr_prev_d;
      best_metric_q  <= best_metric_d;
      best_phase_q   <= best_phase_d;
      best_frac_q    <= best_frac_d;
      best_doppler_q <= best_doppler_d;
      busy_q         <= busy_d;
      eng_start_q    <= eng_start_d;
      res_valid_q    <= res_valid_d;
      res_sat_q      <= res_sat_d;
      res_phase_q    <= res_phase_d;
      res_frac_q     <= res_frac_d;
      res_doppler_q  <= res_doppler_d;
      res_metric_q   <= res_metric_d;
      res_detect_q   <= res_detect_d;
      done_q         <= done_d;
`ifdef ACQ_SCHED_TIMEOUT_EN
      cnt_q          <= cnt_d;
      err_q          <= err_d;
`endif
    end
  end

  assign eng_start         = eng_start_q;
  assign eng_sat           = sat_q;
  assign eng_doppler_omega = omega_q;
  assign busy              = busy_q;
  assign res_valid         = res_valid_q;
  assign res_sat           = res_sat_q;
  assign res_code_phase    = res_phase_q;
  assign res_frac          = res_frac_q;
  assign res_doppler       = res_doppler_q;
  assign res_metric        = res_metric_q;
  assign res_detect        = res_detect_q;
  assign done              = done_q;
`ifdef ACQ_SCHED_TIMEOUT_EN
  assign err_timeout       = err_q;
`else
  assign err_timeout       = 1'b0;
`endif

endmodule
